// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, registered-read data memory between a
// fixed-priority CPU port (A) and a secondary master (B). B is guaranteed
// service by a starvation counter that forces a grant after WAIT_LIMIT stalls.
// Optional feature macro: DMEM_ARB_ALIGN_CHECK_EN (misaligned / out-of-range
// accesses are granted but suppressed and flagged on err).
module dmem_arbiter #(
    parameter int DEPTH      = 256,
    parameter int ADDR_LSB   = 2,
    parameter int WAIT_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        a_req_i,
    input  logic        a_we_i,
    input  logic [31:0] a_addr_i,
    input  logic [31:0] a_wdata_i,
    output logic        a_gnt_o,
    output logic        a_rvalid_o,
    output logic [31:0] a_rdata_o,
    output logic        a_err_o,
    input  logic        b_req_i,
    input  logic        b_we_i,
    input  logic [31:0] b_addr_i,
    input  logic [31:0] b_wdata_i,
    output logic        b_gnt_o,
    output logic        b_rvalid_o,
    output logic [31:0] b_rdata_o,
    output logic        b_err_o,
    output logic        mem_we_o,
    output logic        mem_re_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);
    localparam int          IW      = $clog2(DEPTH);
    localparam logic [3:0]  LIMIT   = 4'(WAIT_LIMIT);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic {IDLE, RDATA} state_t;

    state_t     state_reg, state_next;
    logic       owner_reg, owner_next;      // 0 = A, 1 = B
    logic [3:0] wait_cnt_reg, wait_cnt_next;
    logic       rerr_reg, rerr_next;        // pending read was a rejected access

    // Per-port views so both ports share one generate body (index 0 = A, 1 = B)
    logic [1:0]  req, we, gnt, rvalid, err, bad;
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [31:0] rdata  [2];
    logic [1:0]  unused_bits;

    assign req      = {b_req_i, a_req_i};
    assign we       = {b_we_i, a_we_i};
    assign addr[0]  = a_addr_i;
    assign addr[1]  = b_addr_i;
    assign wdata[0] = a_wdata_i;
    assign wdata[1] = b_wdata_i;

    logic grant_any;
    logic sel;

    // Arbitration: only in IDLE; a starved B overrides A's fixed priority
    always_comb begin
        grant_any = 1'b0;
        sel       = 1'b0;
        if (!rst_i && state_reg == IDLE) begin
            if (req[1] && wait_cnt_reg == LIMIT) begin
                grant_any = 1'b1;
                sel       = 1'b1;
            end else if (req[0]) begin
                grant_any = 1'b1;
                sel       = 1'b0;
            end else if (req[1]) begin
                grant_any = 1'b1;
                sel       = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            // Bits outside the word index are deliberately ignored when unchecked
            assign unused_bits[gi] = ^{addr[gi][31:ADDR_LSB+IW], addr[gi][ADDR_LSB-1:0]};
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            assign bad[gi] = (|addr[gi][ADDR_LSB-1:0]) || ((addr[gi] >> ADDR_LSB) >= DEPTH_W);
            assign err[gi] = (gnt[gi] && we[gi] && bad[gi]) || (rvalid[gi] && rerr_reg);
`else
            assign bad[gi] = 1'b0;
            assign err[gi] = 1'b0;
`endif
            assign gnt[gi]    = grant_any && (sel == 1'(gi));
            // Reset in the RDATA cycle suppresses the pending response
            assign rvalid[gi] = !rst_i && state_reg == RDATA && owner_reg == 1'(gi);
            assign rdata[gi]  = (rvalid[gi] && !rerr_reg) ? mem_rdata_i : 32'd0;
        end
    endgenerate

    assign a_gnt_o    = gnt[0];
    assign b_gnt_o    = gnt[1];
    assign a_rvalid_o = rvalid[0];
    assign b_rvalid_o = rvalid[1];
    assign a_rdata_o  = rdata[0];
    assign b_rdata_o  = rdata[1];
    assign a_err_o    = err[0];
    assign b_err_o    = err[1];

    // Memory-side strobes and winner's address/data; all zero when nothing is granted
    always_comb begin
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        if (grant_any) begin
            mem_we_o    = we[sel] && !bad[sel];
            mem_re_o    = !we[sel] && !bad[sel];
            mem_addr_o  = 32'(addr[sel][ADDR_LSB+IW-1:ADDR_LSB]);
            mem_wdata_o = wdata[sel];
        end
    end

    // Next state: reads spend one cycle in RDATA; starvation counter tracks B stalls
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rerr_next     = rerr_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (grant_any && !we[sel]) begin
                    state_next = RDATA;
                    owner_next = sel;
                    rerr_next  = bad[sel];
                end
            end
            RDATA: begin
                state_next = IDLE;
                rerr_next  = 1'b0;
            end
            default: state_next = IDLE;
        endcase
        if (!req[1] || gnt[1]) begin
            wait_cnt_next = 4'd0;
        end else if (wait_cnt_reg < LIMIT) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            owner_reg    <= 1'b0;
            wait_cnt_reg <= 4'd0;
            rerr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            wait_cnt_reg <= wait_cnt_next;
            rerr_reg     <= rerr_next;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed jobs per port, expected events
// queued up front, a negedge monitor pops and compares each grant/rvalid cycle.
module tb_dmem_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        a_req_i, a_we_i, b_req_i, b_we_i;
    logic [31:0] a_addr_i, a_wdata_i, b_addr_i, b_wdata_i;
    logic        a_gnt_o, a_rvalid_o, a_err_o, b_gnt_o, b_rvalid_o, b_err_o;
    logic [31:0] a_rdata_o, b_rdata_o;
    logic        mem_we_o, mem_re_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'd0;

    always #5 clk_i = ~clk_i;

    dmem_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
        .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
        .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
        .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o), .b_err_o(b_err_o),
        .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // Single-port memory with registered read
    logic [31:0] mem [256];
    always @(posedge clk_i) begin
        if (mem_we_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;
        if (mem_re_o) mem_rdata_i <= mem[mem_addr_o[7:0]];
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } job_t;

    typedef struct {
        string       name;
        logic [3:0]  ev;      // {a_gnt, b_gnt, a_rvalid, b_rvalid}
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ardata;
        logic [31:0] brdata;
        logic [1:0]  err;     // {a_err, b_err}
        int          gap;     // cycles since previous event, 0 = don't care
    } exp_t;

    job_t a_jobs[$];
    job_t b_jobs[$];
    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;
    int   last_ev    = 0;

    always @(posedge clk_i) cycle <= cycle + 1;

    // Port drivers: present the head job until it is granted
    initial begin
        a_req_i = 0; a_we_i = 0; a_addr_i = 0; a_wdata_i = 0;
        forever begin
            @(posedge clk_i); #1;
            if (a_jobs.size() > 0) begin
                a_req_i = 1; a_we_i = a_jobs[0].we; a_addr_i = a_jobs[0].addr; a_wdata_i = a_jobs[0].wdata;
            end else begin
                a_req_i = 0; a_we_i = 0; a_addr_i = 0; a_wdata_i = 0;
            end
        end
    end

    initial begin
        b_req_i = 0; b_we_i = 0; b_addr_i = 0; b_wdata_i = 0;
        forever begin
            @(posedge clk_i); #1;
            if (b_jobs.size() > 0) begin
                b_req_i = 1; b_we_i = b_jobs[0].we; b_addr_i = b_jobs[0].addr; b_wdata_i = b_jobs[0].wdata;
            end else begin
                b_req_i = 0; b_we_i = 0; b_addr_i = 0; b_wdata_i = 0;
            end
        end
    end

    // Monitor: every cycle with a grant or rvalid consumes one expected event
    always @(negedge clk_i) begin
        logic [3:0] ev;
        exp_t       e;
        int         g;
        ev = {a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o};
        if (ev != 4'd0) begin
            compared++;
            g = cycle - last_ev;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event: got ev=%b addr=%h, required no event", ev, mem_addr_o);
            end else begin
                e = exp_q.pop_front();
                if (ev !== e.ev || mem_we_o !== e.we || mem_re_o !== e.re || mem_addr_o !== e.addr ||
                    mem_wdata_o !== e.wdata || a_rdata_o !== e.ardata || b_rdata_o !== e.brdata ||
                    {a_err_o, b_err_o} !== e.err || (e.gap != 0 && g != e.gap)) begin
                    mismatched++;
                    $display("FAIL %s: got ev=%b we=%b re=%b addr=%h wd=%h ard=%h brd=%h err=%b gap=%0d; required ev=%b we=%b re=%b addr=%h wd=%h ard=%h brd=%h err=%b gap=%0d",
                             e.name, ev, mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o, a_rdata_o, b_rdata_o,
                             {a_err_o, b_err_o}, g, e.ev, e.we, e.re, e.addr, e.wdata, e.ardata, e.brdata, e.err, e.gap);
                end else begin
                    $display("ok %s: ev=%b addr=%h wd=%h ard=%h brd=%h", e.name, ev, mem_addr_o, mem_wdata_o, a_rdata_o, b_rdata_o);
                end
            end
            last_ev = cycle;
        end
        if (a_gnt_o && a_jobs.size() > 0) void'(a_jobs.pop_front());
        if (b_gnt_o && b_jobs.size() > 0) void'(b_jobs.pop_front());
    end

    task automatic job(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        job_t j;
        j.we = we; j.addr = addr; j.wdata = wdata;
        if (port) b_jobs.push_back(j);
        else a_jobs.push_back(j);
    endtask

    task automatic expect_ev(input string name, input logic [3:0] ev, input logic we, input logic re,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] ardata,
                             input logic [31:0] brdata, input logic [1:0] err, input int gap);
        exp_t e;
        e.name = name; e.ev = ev; e.we = we; e.re = re; e.addr = addr; e.wdata = wdata;
        e.ardata = ardata; e.brdata = brdata; e.err = err; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic gnt_wr(input string name, input bit port, input logic [31:0] idx, input logic [31:0] wd, input int gap);
        expect_ev(name, port ? 4'b0100 : 4'b1000, 1'b1, 1'b0, idx, wd, 32'd0, 32'd0, 2'b00, gap);
    endtask

    task automatic gnt_rd(input string name, input bit port, input logic [31:0] idx, input int gap);
        expect_ev(name, port ? 4'b0100 : 4'b1000, 1'b0, 1'b1, idx, 32'd0, 32'd0, 32'd0, 2'b00, gap);
    endtask

    task automatic rv(input string name, input bit port, input logic [31:0] data, input int gap);
        expect_ev(name, port ? 4'b0001 : 4'b0010, 1'b0, 1'b0, 32'd0, 32'd0,
                  port ? 32'd0 : data, port ? data : 32'd0, 2'b00, gap);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        compared++;
        if (got !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else begin
            $display("ok %s: %h", name, got);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_ctrl"}, 64'({a_gnt_o, a_rvalid_o, a_err_o, b_gnt_o, b_rvalid_o, b_err_o, mem_we_o, mem_re_o}), 64'd0);
        chk({name, "_mem"}, {mem_addr_o, mem_wdata_o}, 64'd0);
        chk({name, "_rdata"}, {a_rdata_o, b_rdata_o}, 64'd0);
    endtask

    // Wait until all jobs and expected events are consumed, then idle two cycles
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || a_jobs.size() != 0 || b_jobs.size() != 0) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0 || a_jobs.size() != 0 || b_jobs.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete(); a_jobs.delete(); b_jobs.delete();
        end
        repeat (2) @(posedge clk_i);
        #2;
    endtask

    initial begin
        int n;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_idle_outputs("reset_hold");
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk_idle_outputs("after_reset");
        @(posedge clk_i); #2;

        // Basic write then read on A
        job(0, 1, 32'h10, 32'hDEADBEEF);
        job(0, 0, 32'h10, 32'h0);
        gnt_wr("a_write_0x10", 0, 32'd4, 32'hDEADBEEF, 0);
        gnt_rd("a_read_0x10", 0, 32'd4, 1);
        rv("a_rvalid_0x10", 0, 32'hDEADBEEF, 1);
        drain("basic");

        // Simultaneous writes: A first, B next cycle
        job(0, 1, 32'h40, 32'h11111111);
        job(1, 1, 32'h80, 32'h22222222);
        gnt_wr("sim_a_write", 0, 32'h10, 32'h11111111, 0);
        gnt_wr("sim_b_write", 1, 32'h20, 32'h22222222, 1);
        drain("sim_wr");

        // Simultaneous reads: A read, A data, then B read, B data
        job(0, 0, 32'h80, 32'h0);
        job(1, 0, 32'h40, 32'h0);
        gnt_rd("sim_a_read", 0, 32'h20, 0);
        rv("sim_a_rvalid", 0, 32'h22222222, 1);
        gnt_rd("sim_b_read", 1, 32'h10, 1);
        rv("sim_b_rvalid", 1, 32'h11111111, 1);
        drain("sim_rd");

        // Seed B's target for the starvation read
        job(1, 1, 32'h20, 32'hCAFEF00D);
        gnt_wr("b_write_0x20", 1, 32'd8, 32'hCAFEF00D, 0);
        drain("seed");

        // Starvation: B wins on the 5th cycle of its request
        for (int k = 0; k < 8; k++) job(0, 1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
        job(1, 0, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) gnt_wr("starve_a_write", 0, 32'h40 + 32'(k), 32'hA0 + 32'(k), (k == 0) ? 0 : 1);
        gnt_rd("starve_b_read", 1, 32'd8, 1);
        rv("starve_b_rvalid", 1, 32'hCAFEF00D, 1);
        for (int k = 4; k < 8; k++) gnt_wr("starve_a_write", 0, 32'h40 + 32'(k), 32'hA0 + 32'(k), 1);
        drain("starve");

        // Reset asserted during the RDATA cycle drops the response
        job(0, 0, 32'h10, 32'h0);
        gnt_rd("rst_a_read", 0, 32'd4, 0);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!a_gnt_o && n < 20);
        chk("rst_read_granted", 64'(a_gnt_o), 64'd1);
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_no_rvalid", 64'({a_rvalid_o, b_rvalid_o}), 64'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk_idle_outputs("post_rst");
        drain("rst");

`ifndef DMEM_ARB_ALIGN_CHECK_EN
        // Address wrap: 0x404 and 0x004 share index 1
        job(0, 1, 32'h404, 32'h5A5A1234);
        job(0, 0, 32'h004, 32'h0);
        gnt_wr("wrap_write_0x404", 0, 32'd1, 32'h5A5A1234, 0);
        gnt_rd("wrap_read_0x004", 0, 32'd1, 1);
        rv("wrap_rvalid", 0, 32'h5A5A1234, 1);
        drain("wrap");

        // Low address bits ignored: 0x13 writes index 4
        job(0, 1, 32'h13, 32'h77777777);
        job(0, 0, 32'h10, 32'h0);
        gnt_wr("lowbits_write_0x13", 0, 32'd4, 32'h77777777, 0);
        gnt_rd("lowbits_read_0x10", 0, 32'd4, 1);
        rv("lowbits_rvalid", 0, 32'h77777777, 1);
        drain("lowbits");
`else
        // Misaligned write is granted, suppressed and flagged
        job(0, 1, 32'h13, 32'h77777777);
        job(0, 0, 32'h10, 32'h0);
        expect_ev("misaligned_write", 4'b1000, 1'b0, 1'b0, 32'd4, 32'h77777777, 32'd0, 32'd0, 2'b10, 0);
        gnt_rd("after_misaligned_read", 0, 32'd4, 1);
        rv("after_misaligned_rvalid", 0, 32'hDEADBEEF, 1);
        drain("misaligned");

        // Out-of-range read: RDATA with zero data and err
        job(0, 0, 32'h400, 32'h0);
        expect_ev("oor_read", 4'b1000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 0);
        expect_ev("oor_rvalid", 4'b0010, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b10, 1);
        drain("oor");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
